// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32I ID decode plus ID/EX, EX/MEM, MEM/WB control pipeline
// with stall/flush and branch/jump resolution in EX.
module pipelined_control_unit #(
  parameter int ALU_CTRL_W = 3,
  parameter int IMM_SRC_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic                  zero_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  output logic [IMM_SRC_W-1:0]  ImmSrc_d,
  output logic                  illegal_d,
  output logic [ALU_CTRL_W-1:0] ALUControl_e,
  output logic                  ALUSrc_e,
  output logic                  ALUASrc_e,
  output logic                  PCSrc_e,
  output logic                  JalrSel_e,
  output logic                  MemWrite_m,
  output logic                  RegWrite_m,
  output logic                  RegWrite_w,
  output logic [1:0]            ResultSrc_w,
  output logic                  ResultSrc_e0
);
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic [1:0]            result_src;
    logic                  branch;
    logic                  jump;
    logic                  jalr_sel;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_src;
    logic                  alu_a_src;
    logic [2:0]            funct3;
  } ctrl_t;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7;
  logic [3:0] alu_op;
  logic       ext_op;
  logic       ill;
  logic [2:0] imm;
  ctrl_t      dec;
  ctrl_t      de;
  logic       em_reg_write;
  logic       em_mem_write;
  logic [1:0] em_result_src;
  logic       mw_reg_write;
  logic [1:0] mw_result_src;
  logic       unused_bits;
  assign op = instr_d[6:0];
  assign f3 = instr_d[14:12];
  assign f7 = instr_d[30];
  assign unused_bits = ^{instr_d[31], instr_d[29:15], instr_d[11:7]};
  // shifts and sltu only exist in the 4-bit ALU op set
  assign ext_op = f3 == 3'b001 || f3 == 3'b011 || f3 == 3'b101;
  assign alu_op = f3 == 3'b000 ? {3'b000, op == OP_R && f7} :
                  f3 == 3'b001 ? 4'd7 :
                  f3 == 3'b010 ? 4'd5 :
                  f3 == 3'b011 ? 4'd6 :
                  f3 == 3'b100 ? 4'd4 :
                  f3 == 3'b101 ? (f7 ? 4'd9 : 4'd8) :
                  f3 == 3'b110 ? 4'd3 : 4'd2;
  always_comb begin
    dec = '0;
    imm = 3'b000;
    ill = 1'b0;
    dec.funct3 = f3;
    case (op)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl = ALU_CTRL_W'(alu_op);
        ill = ext_op && ALU_CTRL_W < 4;
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_ctrl = ALU_CTRL_W'(alu_op);
        ill = ext_op && ALU_CTRL_W < 4;
      end
      OP_LOAD: begin
        dec.reg_write = 1'b1;
        dec.alu_src = 1'b1;
        dec.result_src = 2'b01;
        ill = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OP_ST: begin
        dec.mem_write = 1'b1;
        dec.alu_src = 1'b1;
        imm = 3'b001;
        ill = f3[2] || f3 == 3'b011;
      end
      OP_BR: begin
        dec.branch = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        imm = 3'b010;
        ill = f3[2:1] == 2'b01;
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump = 1'b1;
        dec.result_src = 2'b10;
        imm = 3'b011;
      end
      OP_JALR: begin
        dec.reg_write = 1'b1;
        dec.jump = 1'b1;
        dec.jalr_sel = 1'b1;
        dec.alu_src = 1'b1;
        dec.result_src = 2'b10;
        ill = f3 != 3'b000;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_a_src = 1'b1;
        imm = 3'b100;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec = '0;
      imm = 3'b000;
    end
  end
  assign ImmSrc_d = IMM_SRC_W'(imm);
  assign illegal_d = ill;
  // flush squashes only ID/EX; the older stages keep draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de <= '0;
      em_reg_write <= 1'b0;
      em_mem_write <= 1'b0;
      em_result_src <= 2'b00;
      mw_reg_write <= 1'b0;
      mw_result_src <= 2'b00;
    end else begin
      if (flush_e || !stall_e) begin
        em_reg_write <= de.reg_write;
        em_mem_write <= de.mem_write;
        em_result_src <= de.result_src;
        mw_reg_write <= em_reg_write;
        mw_result_src <= em_result_src;
      end
      if (flush_e) de <= '0;
      else if (!stall_e) de <= dec;
    end
  end
  assign ALUControl_e = de.alu_ctrl;
  assign ALUSrc_e = de.alu_src;
  assign ALUASrc_e = de.alu_a_src;
  assign JalrSel_e = de.jalr_sel;
  assign ResultSrc_e0 = de.result_src[0];
  // funct3[2:1] picks eq/lt/ltu, funct3[0] inverts it
  assign PCSrc_e = de.jump || (de.branch &&
                   ((de.funct3[2] ? (de.funct3[1] ? ltu_e : lt_e) : zero_e) ^ de.funct3[0]));
  assign MemWrite_m = em_mem_write;
  assign RegWrite_m = em_reg_write;
  assign RegWrite_w = mw_reg_write;
  assign ResultSrc_w = mw_result_src;
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation control unit for the 5-stage pipelined RV32I core.
- Decodes the instruction in ID and produces ID-stage immediate select and an illegal-instruction flag.
- Carries the control bundle through internal ID/EX, EX/MEM and MEM/WB registers, with bubble (flush) and hold (stall) support.
- Resolves taken branches and jumps in EX, including the full RV32I branch-condition set. Adds JAL, JALR and LUI decoding, and a selectable ALU control width.

Parameters:
- ALU_CTRL_W, 3, ALUControl width. 3 gives the base op set; 4 gives the extended op set (shifts, sltu, srl/sra).
- IMM_SRC_W, 3, ImmSrc width. Minimum 3; must cover I/S/B/J/U.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- instr_d  input  32  instruction in ID.
- stall_e  input  1  hold the ID/EX, EX/MEM and MEM/WB registers.
- flush_e  input  1  load a bubble into ID/EX.
- zero_e  input  1  ALU result == 0.
- lt_e  input  1  signed rs1 < rs2.
- ltu_e  input  1  unsigned rs1 < rs2.
- ImmSrc_d  output  IMM_SRC_W  ID immediate select: 000 I, 001 S, 010 B, 011 J, 100 U.
- illegal_d  output  1  unsupported encoding in ID.
- ALUControl_e  output  ALU_CTRL_W  EX ALU operation.
- ALUSrc_e  output  1  0 = rs2, 1 = immediate.
- ALUASrc_e  output  1  1 = zero as operand A (LUI).
- PCSrc_e  output  1  redirect PC (taken branch or jump).
- JalrSel_e  output  1  target = ALU result (JALR); otherwise PC + imm.
- MemWrite_m  output  1  store enable in MEM.
- RegWrite_m  output  1  forwarding qualifier.
- RegWrite_w  output  1  register-file write enable.
- ResultSrc_w  output  2  WB mux: 00 ALU, 01 memory, 10 PC+4.
- ResultSrc_e0  output  1  load in EX (load-use hazard detection).

Behaviour:
- Decode (combinational, ID), by opcode:
  - 0110011 R-type, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI.
  - Any other opcode, or funct3 not legal for the opcode, gives illegal_d = 1. An illegal instruction is decoded as a bubble: all write enables 0, Branch 0, Jump 0.
- ALU codes, 3-bit set: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
  - With the 3-bit set, sll/srl/sra/sltu (R-type and I-type) are illegal.
  - ALU_CTRL_W = 4 keeps the same low codes zero-extended and adds 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- Sub and sra are selected by funct7[5]:
  - R-type: funct7[5] selects both sub and sra.
  - I-type: funct7[5] selects sra only; addi never decodes as sub.
- Branches use sub. Loads, stores, JALR and LUI use add. LUI sets ALUASrc = 1.
- Pipeline registers: ID/EX, EX/MEM and MEM/WB hold the control bundle plus funct3.
  - Fields carried: RegWrite, MemWrite, ResultSrc, Branch, Jump, JalrSel, ALUControl, ALUSrc, ALUASrc, funct3.
  - Every clock edge advances all three registers unless stall_e = 1.
  - stall_e = 1: all three registers hold their values.
  - flush_e = 1 (priority over stall_e): ID/EX loads the all-zero bubble, while EX/MEM and MEM/WB still advance.
- PCSrc_e (combinational from ID/EX) = Jump_e | (Branch_e & cond), by funct3_e:
  - 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
- Latency:
  - ID decode appears in EX outputs 1 cycle later, MEM outputs 2 cycles later, WB outputs 3 cycles later.
  - ImmSrc_d and illegal_d are 0-cycle (combinational).
- Reset: rst asserts asynchronously. Every register clears to the bubble, so all registered outputs are 0 (ALUControl 0 = add, ResultSrc 00, PCSrc_e 0).
  - Release is synchronous to the next clk edge.
  - A reset mid-stream discards all in-flight controls; no partial writes follow.
- A taken branch or jump must not itself write memory. The hazard unit asserts flush_e on the following cycle to squash the wrong-path instruction in ID; this block does not self-flush.

Test Plan:
- add x3,x1,x2 (0x002081B3) then NOPs: cycle+1 ALUControl_e = 000, ALUSrc_e = 0; cycle+3 RegWrite_w = 1, ResultSrc_w = 00.
- sub 0x402081B3, then lw 0x0000A283: ALUControl_e = 001, then 000 with ALUSrc_e = 1 and ResultSrc_e0 = 1; lw reaches WB with ResultSrc_w = 01.
- beq 0x00208463 with zero_e = 1: PCSrc_e = 1. Same with zero_e = 0: PCSrc_e = 0. bltu with ltu_e = 1: PCSrc_e = 1. RegWrite and MemWrite stay 0 through WB.
- sll 0x002091B3 with ALU_CTRL_W = 3: illegal_d = 1, bubble propagates. With ALU_CTRL_W = 4: ALUControl_e = 0111, illegal_d = 0.
- sw in ID with stall_e = 1 for 2 cycles: EX/MEM/WB outputs frozen. Same with flush_e = 1: MemWrite_m never asserts.
- jal 0x008000EF in flight, rst pulsed between clk edges: all outputs 0 immediately; RegWrite_w never rises for the jal.
